debug_control_unit: RTL and testbench
=====================================

// Module: debug_control_unit
// PURPOSE
// Host-side controller sitting directly upstream of the pipeline top: turns UART byte traffic into
// pipeline control (program load into instruction memory, run, single-step) and streams machine
// state (PC, register bank, data memory) back to the host. Owns i_enable_pipe/i_debug_unit and the
// debug read ports of the register bank and data memory; consumes o_halt and the debug data buses.
// PARAMETERS
// NB_DATA    32          pipeline data/instruction width
// NB_BYTE    8           UART byte width
// NB_REG     5           register-bank address width
// N_REGISTER 32          registers dumped per report
// DM_WORDS   32          data-memory words dumped per report
// IM_DEPTH   256         instruction-memory words; load wraps never (stops at IM_DEPTH)
// HALT_WORD  32'hFC00_0000  instruction encoding that terminates a program load
// PORTS
// i_clock            in   1          system clock
// i_reset            in   1          asynchronous, active-low reset
// i_rx_data          in   NB_BYTE    received byte
// i_rx_done          in   1          1-cycle strobe: i_rx_data valid
// i_tx_done          in   1          1-cycle strobe: UART TX finished current byte
// o_tx_data          out  NB_BYTE    byte to send
// o_tx_start         out  1          1-cycle strobe: start sending o_tx_data
// i_pc               in   ADDRWIDTH  pipeline PC (o_data_send_pc)
// i_reg_data         in   NB_DATA    register-bank debug read data
// i_mem_data         in   NB_DATA    data-memory debug read data
// i_halt             in   1          pipeline halt reached WB
// o_im_data          out  NB_DATA    word to write into instruction memory
// o_im_addr          out  ADDRWIDTH  instruction-memory write address
// o_im_enable_write  out  1          instruction-memory write strobe
// o_enable_pipe      out  1          advance pipeline this cycle
// o_debug_unit       out  1          1 while unit owns IM / pipeline is parked
// o_br_addr          out  NB_REG     register-bank debug read address
// o_br_enable        out  1          register-bank debug read enable
// o_dm_addr          out  ADDRWIDTH  data-memory debug read address
// o_dm_enable        out  1          data-memory debug read enable
// BEHAVIOUR
// - Reset (async, i_reset=0): state IDLE; all strobes/enables 0, addresses 0, o_tx_data 0, o_debug_unit 1.
// - Commands (ASCII byte in IDLE): 'L'=load, 'C'=continuous run, 'S'=single step. Others ignored.
// - LOAD: collect 4 bytes LSB-first into a word; cycle after 4th byte: o_im_enable_write=1 for one cycle
//   at o_im_addr, then addr+1. Ends after writing HALT_WORD or after word IM_DEPTH-1; then send
//   ack byte 8'h4C and return to IDLE. Address counter cleared at each 'L'.
// - RUN ('C'): o_debug_unit=0, o_enable_pipe=1 every cycle until i_halt=1; enable drops the same
//   cycle i_halt is sampled high; then DUMP.
// - STEP ('S'): o_enable_pipe=1 for exactly one cycle, then DUMP. If i_halt already 1, no enable pulse,
//   DUMP only. Further 'S' bytes received during DUMP are dropped.
// - DUMP order: PC (4 bytes), R0..R(N_REGISTER-1) (4 bytes each), DM word 0..DM_WORDS-1 (4 bytes
//   each); every word LSB-first. Total 4*(1+N_REGISTER+DM_WORDS) bytes; then IDLE.
// - Reads: drive address+enable, wait 1 cycle (read latency 1), latch word, then send 4 bytes.
// - TX handshake: o_tx_start pulses 1 cycle with stable o_tx_data; next byte only after i_tx_done.
//   Never two starts without an intervening i_tx_done. o_tx_data held until i_tx_done.
// - States: IDLE, LD_BYTE, LD_WRITE, LD_ACK, RUN, STEP, RD_ADDR, RD_LATCH, TX_BYTE, TX_WAIT.
// - Counters: byte index 2 bits (wraps 3->0 per word); word index sized for max(N_REGISTER, DM_WORDS).
// - i_rx_done outside IDLE/LD_BYTE is ignored. i_halt asserted during LOAD is ignored.
// - Async reset mid-LOAD/RUN/DUMP aborts immediately; partial word discarded, no TX started.
// STRUCTURE
// - Command codes, ack byte, state encoding, dump ordering constants -> shared `parameters.vh`.
// - One sub-module: dbg_word_serializer (latched 32-bit word -> 4 byte TX handshake sequence).
// TESTING
// - Reset: hold i_reset=0 mid-RUN -> o_enable_pipe=0, o_tx_start=0, o_debug_unit=1 within 0 cycles.
// - 'L',[13 00 20 00],[00 00 00 FC] -> IM writes 0x00200013@0, 0xFC000000@1; ack 0x4C sent.
// - 'S' with program loaded -> exactly one o_enable_pipe cycle; 4+128+128 bytes, first 4 = PC LSB-first.
// - 'C', force i_halt=1 after 20 cycles -> 20 enable cycles, enable low same cycle as halt, dump follows.
// - TX stall: delay i_tx_done 50 cycles per byte -> no second o_tx_start before i_tx_done; byte order kept.
// - Load 257 non-halt words with IM_DEPTH=256 -> writes stop at addr 255, ack sent, extra bytes dropped.

Source files
------------

// File: rtl/debug_control_unit_pkg.sv
// Shared constants and types for the host debug controller.
// Command bytes, ack byte, FSM states and dump sections.
package debug_control_unit_pkg;

  localparam logic [7:0] CMD_LOAD = 8'h4C;
  localparam logic [7:0] CMD_RUN  = 8'h43;
  localparam logic [7:0] CMD_STEP = 8'h53;
  localparam logic [7:0] ACK_BYTE = 8'h4C;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_LD_BYTE,
    ST_LD_WRITE,
    ST_LD_ACK,
    ST_RUN,
    ST_STEP,
    ST_RD_ADDR,
    ST_RD_LATCH,
    ST_TX_BYTE,
    ST_TX_WAIT
  } dcu_state_e;

  // Dump order: PC first, then registers, then data memory
  typedef enum logic [1:0] {
    SEC_PC,
    SEC_REG,
    SEC_DM
  } dump_sec_e;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/debug_control_unit_serializer.sv
// Sends a latched word to the UART one byte at a time, LSB first.
// One byte in flight; the next start waits for tx_done.
module debug_control_unit_serializer #(
  parameter int NB_DATA = 32,
  parameter int NB_BYTE = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic               single,
  input  logic [NB_DATA-1:0] word,
  input  logic               tx_done,
  output logic [NB_BYTE-1:0] tx_data,
  output logic               tx_start,
  output logic               done
);

  localparam int NB_REST = NB_DATA - NB_BYTE;

  logic               busy;
  logic [1:0]         idx;
  logic [1:0]         last;
  logic [NB_REST-1:0] rest;

  // Byte sequencer; a done seen while start is still high is ignored
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy     <= 1'b0;
      idx      <= 2'd0;
      last     <= 2'd0;
      rest     <= '0;
      tx_data  <= '0;
      tx_start <= 1'b0;
      done     <= 1'b0;
    end else begin
      tx_start <= 1'b0;
      done     <= 1'b0;
      if (!busy) begin
        if (load) begin
          busy     <= 1'b1;
          idx      <= 2'd0;
          last     <= single ? 2'd0 : 2'd3;
          rest     <= word[NB_DATA-1:NB_BYTE];
          tx_data  <= word[NB_BYTE-1:0];
          tx_start <= 1'b1;
        end
      end else if (tx_done && !tx_start) begin
        if (idx == last) begin
          busy <= 1'b0;
          done <= 1'b1;
        end else begin
          idx      <= idx + 2'd1;
          tx_data  <= rest[NB_BYTE-1:0];
          rest     <= rest >> NB_BYTE;
          tx_start <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/debug_control_unit.sv
// Host debug controller: UART commands drive program load,
// run and single step, then stream PC, registers and DM back.
module debug_control_unit
  import debug_control_unit_pkg::*;
#(
  parameter int NB_DATA    = 32,
  parameter int NB_BYTE    = 8,
  parameter int NB_REG     = 5,
  parameter int N_REGISTER = 32,
  parameter int DM_WORDS   = 32,
  parameter int IM_DEPTH   = 256,
  parameter int ADDRWIDTH  = 8,
  parameter logic [NB_DATA-1:0] HALT_WORD = 32'hFC00_0000
) (
  input  logic                 i_clock,
  input  logic                 i_reset,
  input  logic [NB_BYTE-1:0]   i_rx_data,
  input  logic                 i_rx_done,
  input  logic                 i_tx_done,
  output logic [NB_BYTE-1:0]   o_tx_data,
  output logic                 o_tx_start,
  input  logic [ADDRWIDTH-1:0] i_pc,
  input  logic [NB_DATA-1:0]   i_reg_data,
  input  logic [NB_DATA-1:0]   i_mem_data,
  input  logic                 i_halt,
  output logic [NB_DATA-1:0]   o_im_data,
  output logic [ADDRWIDTH-1:0] o_im_addr,
  output logic                 o_im_enable_write,
  output logic                 o_enable_pipe,
  output logic                 o_debug_unit,
  output logic [NB_REG-1:0]    o_br_addr,
  output logic                 o_br_enable,
  output logic [ADDRWIDTH-1:0] o_dm_addr,
  output logic                 o_dm_enable
);

  localparam int MAXW   = max_int(N_REGISTER, DM_WORDS);
  localparam int NB_IDX = (MAXW > 1) ? $clog2(MAXW) : 1;
  localparam int NB_BUF = NB_DATA - NB_BYTE;

  localparam logic [NB_IDX-1:0] LAST_REG =
    NB_IDX'(N_REGISTER - 1);
  localparam logic [NB_IDX-1:0] LAST_DM =
    NB_IDX'(DM_WORDS - 1);
  localparam logic [ADDRWIDTH-1:0] LAST_IM =
    ADDRWIDTH'(IM_DEPTH - 1);

  dcu_state_e         state;
  dump_sec_e          sec;
  dump_sec_e          nxt_sec;
  logic [NB_IDX-1:0]  idx;
  logic [NB_IDX-1:0]  nxt_idx;
  logic               last_item;
  logic [1:0]         byte_idx;
  logic [NB_BUF-1:0]  word_buf;
  logic               en_q;
  logic               ser_load;
  logic               ser_single;
  logic [NB_DATA-1:0] ser_word;
  logic               ser_done;

  // Halt cuts the run enable in the very cycle it is seen
  assign o_enable_pipe = en_q & ~((state == ST_RUN) & i_halt);

  // Next dump item after the word just sent
  always_comb begin
    nxt_sec   = sec;
    nxt_idx   = idx + NB_IDX'(1);
    last_item = 1'b0;
    unique case (sec)
      SEC_PC: begin
        nxt_sec = SEC_REG;
        nxt_idx = '0;
      end
      SEC_REG: begin
        if (idx == LAST_REG) begin
          nxt_sec = SEC_DM;
          nxt_idx = '0;
        end
      end
      SEC_DM: last_item = (idx == LAST_DM);
      default: last_item = 1'b1;
    endcase
  end

  // Command decode, load, run/step and dump sequencing
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state             <= ST_IDLE;
      sec               <= SEC_PC;
      idx               <= '0;
      byte_idx          <= 2'd0;
      word_buf          <= '0;
      en_q              <= 1'b0;
      ser_load          <= 1'b0;
      ser_single        <= 1'b0;
      ser_word          <= '0;
      o_im_data         <= '0;
      o_im_addr         <= '0;
      o_im_enable_write <= 1'b0;
      o_debug_unit      <= 1'b1;
      o_br_addr         <= '0;
      o_br_enable       <= 1'b0;
      o_dm_addr         <= '0;
      o_dm_enable       <= 1'b0;
    end else begin
      o_im_enable_write <= 1'b0;
      ser_load          <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          unique case (1'b1)
            i_rx_done && i_rx_data == CMD_LOAD: begin
              o_im_addr <= '0;
              byte_idx  <= 2'd0;
              state     <= ST_LD_BYTE;
            end
            i_rx_done && i_rx_data == CMD_RUN: begin
              en_q         <= 1'b1;
              o_debug_unit <= 1'b0;
              state        <= ST_RUN;
            end
            i_rx_done && i_rx_data == CMD_STEP: begin
              sec <= SEC_PC;
              idx <= '0;
              if (i_halt) begin
                state <= ST_RD_ADDR;
              end else begin
                en_q         <= 1'b1;
                o_debug_unit <= 1'b0;
                state        <= ST_STEP;
              end
            end
            default: ;
          endcase
        end
        ST_LD_BYTE: begin
          if (i_rx_done) begin
            word_buf <= {i_rx_data, word_buf[NB_BUF-1:NB_BYTE]};
            byte_idx <= byte_idx + 2'd1;
            if (byte_idx == 2'd3) begin
              o_im_data         <= {i_rx_data, word_buf};
              o_im_enable_write <= 1'b1;
              state             <= ST_LD_WRITE;
            end
          end
        end
        ST_LD_WRITE: begin
          if (o_im_data == HALT_WORD || o_im_addr == LAST_IM) begin
            ser_word   <= NB_DATA'(ACK_BYTE);
            ser_single <= 1'b1;
            ser_load   <= 1'b1;
            state      <= ST_LD_ACK;
          end else begin
            o_im_addr <= o_im_addr + ADDRWIDTH'(1);
            state     <= ST_LD_BYTE;
          end
        end
        ST_LD_ACK: begin
          if (ser_done) state <= ST_IDLE;
        end
        ST_RUN: begin
          if (i_halt) begin
            en_q         <= 1'b0;
            o_debug_unit <= 1'b1;
            sec          <= SEC_PC;
            idx          <= '0;
            state        <= ST_RD_ADDR;
          end
        end
        ST_STEP: begin
          en_q         <= 1'b0;
          o_debug_unit <= 1'b1;
          state        <= ST_RD_ADDR;
        end
        ST_RD_ADDR: begin
          o_br_enable <= 1'b0;
          o_dm_enable <= 1'b0;
          state       <= ST_RD_LATCH;
        end
        ST_RD_LATCH: begin
          unique case (sec)
            SEC_PC:  ser_word <= NB_DATA'(i_pc);
            SEC_REG: ser_word <= i_reg_data;
            default: ser_word <= i_mem_data;
          endcase
          ser_single <= 1'b0;
          ser_load   <= 1'b1;
          state      <= ST_TX_BYTE;
        end
        ST_TX_BYTE: state <= ST_TX_WAIT;
        ST_TX_WAIT: begin
          if (ser_done) begin
            if (last_item) begin
              state <= ST_IDLE;
            end else begin
              sec         <= nxt_sec;
              idx         <= nxt_idx;
              o_br_enable <= (nxt_sec == SEC_REG);
              o_br_addr   <= NB_REG'(nxt_idx);
              o_dm_enable <= (nxt_sec == SEC_DM);
              o_dm_addr   <= ADDRWIDTH'(nxt_idx);
              state       <= ST_RD_ADDR;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  debug_control_unit_serializer #(
    .NB_DATA(NB_DATA),
    .NB_BYTE(NB_BYTE)
  ) u_ser (
    .clk     (i_clock),
    .rst_n   (i_reset),
    .load    (ser_load),
    .single  (ser_single),
    .word    (ser_word),
    .tx_done (i_tx_done),
    .tx_data (o_tx_data),
    .tx_start(o_tx_start),
    .done    (ser_done)
  );

endmodule

// File: tb/tb_debug_control_unit.sv
// Randomized bench for debug_control_unit: UART host,
// TX responder and pipeline/memory stubs with a reference model.
module tb_debug_control_unit;

  localparam logic [31:0] HALT = 32'hFC00_0000;
  localparam int DUMP_BYTES = 4 * (1 + 32 + 32);

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_done = 1'b0;
  logic        tx_done = 1'b0;
  logic [7:0]  tx_data;
  logic        tx_start;
  logic [7:0]  pc_w;
  logic [31:0] reg_data = '0;
  logic [31:0] mem_data = '0;
  logic        halt = 1'b0;
  logic [31:0] im_data;
  logic [7:0]  im_addr;
  logic        im_we;
  logic        en_pipe;
  logic        dbg;
  logic [4:0]  br_addr;
  logic        br_en;
  logic [7:0]  dm_addr;
  logic        dm_en;

  always #5 clk = ~clk;

  debug_control_unit dut (
    .i_clock          (clk),
    .i_reset          (rst_n),
    .i_rx_data        (rx_data),
    .i_rx_done        (rx_done),
    .i_tx_done        (tx_done),
    .o_tx_data        (tx_data),
    .o_tx_start       (tx_start),
    .i_pc             (pc_w),
    .i_reg_data       (reg_data),
    .i_mem_data       (mem_data),
    .i_halt           (halt),
    .o_im_data        (im_data),
    .o_im_addr        (im_addr),
    .o_im_enable_write(im_we),
    .o_enable_pipe    (en_pipe),
    .o_debug_unit     (dbg),
    .o_br_addr        (br_addr),
    .o_br_enable      (br_en),
    .o_dm_addr        (dm_addr),
    .o_dm_enable      (dm_en)
  );

  int n_chk = 0;
  int n_ok  = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_ok++;
    else $display("FAIL %s: got %h, expected %h", tag, got, exp);
  endtask

  // Pipeline and memory stubs: PC advances per enable cycle,
  // debug reads return data one cycle after the address
  logic [31:0] regs [32];
  logic [31:0] dmem [32];
  logic [7:0]  pc_base = 8'h00;
  int          en_total = 0;

  assign pc_w = pc_base + en_total[7:0];

  always @(posedge clk) begin
    if (br_en) reg_data <= regs[br_addr];
    if (dm_en) mem_data <= dmem[dm_addr[4:0]];
  end

  logic [7:0]  im_a_q [$];
  logic [31:0] im_d_q [$];

  initial forever begin
    @(negedge clk);
    if (en_pipe) en_total++;
    if (im_we) begin
      im_a_q.push_back(im_addr);
      im_d_q.push_back(im_data);
    end
  end

  // UART TX responder: records bytes, answers each start
  logic [7:0] rx_q [$];
  int         pending = 0;
  int         cnt = 0;
  logic [7:0] cur = 8'h00;
  int         ovl_err = 0;
  int         hold_err = 0;
  bit         stall = 1'b0;

  initial forever begin
    @(negedge clk);
    if (!rst_n) pending = 0;
    if (tx_start) begin
      if (pending != 0) ovl_err++;
      pending = 1;
      cur = tx_data;
      rx_q.push_back(tx_data);
      cnt = stall ? 50 : int'($urandom_range(0, 3));
    end else if (pending != 0 && tx_data !== cur) begin
      hold_err++;
    end
    @(posedge clk);
    #1;
    tx_done = 1'b0;
    if (pending != 0) begin
      if (cnt == 0) begin
        tx_done = 1'b1;
        pending = 0;
      end else begin
        cnt--;
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk);
    #1;
    rx_data = b;
    rx_done = 1'b1;
    @(posedge clk);
    #1;
    rx_done = 1'b0;
    repeat ($urandom_range(0, 2)) @(posedge clk);
  endtask

  task automatic wait_bytes(input string tag, input int n,
                            input int limit);
    int c = 0;
    while (rx_q.size() < n && c < limit) begin
      @(negedge clk);
      c++;
    end
    chk({tag, "_timeout"}, (rx_q.size() >= n), 1);
    c = 0;
    while (pending != 0 && c < 100) begin
      @(negedge clk);
      c++;
    end
    repeat (20) @(negedge clk);
  endtask

  // Reference for a load: words from byte groups, LSB first,
  // stopping after the halt word or the last IM address
  logic [7:0]  ld_q [$];
  logic [7:0]  exp_a [$];
  logic [31:0] exp_d [$];

  task automatic model_load();
    logic [31:0] w;
    exp_a.delete();
    exp_d.delete();
    for (int i = 0; i * 4 + 3 < ld_q.size(); i++) begin
      w = {ld_q[i*4+3], ld_q[i*4+2], ld_q[i*4+1], ld_q[i*4]};
      exp_a.push_back(i[7:0]);
      exp_d.push_back(w);
      if (w == HALT || i == 255) break;
    end
  endtask

  task automatic run_load(input string tag);
    int n;
    model_load();
    im_a_q.delete();
    im_d_q.delete();
    rx_q.delete();
    send_byte(8'h4C);
    foreach (ld_q[i]) send_byte(ld_q[i]);
    wait_bytes(tag, 1, 2000);
    chk({tag, "_nwr"}, im_a_q.size(), exp_a.size());
    n = (im_a_q.size() < exp_a.size()) ? im_a_q.size()
                                         : exp_a.size();
    for (int i = 0; i < n; i++) begin
      chk($sformatf("%s_a%0d", tag, i), im_a_q[i], exp_a[i]);
      chk($sformatf("%s_d%0d", tag, i), im_d_q[i], exp_d[i]);
    end
    chk({tag, "_nack"}, rx_q.size(), 1);
    if (rx_q.size() > 0) chk({tag, "_ack"}, rx_q[0], 8'h4C);
  endtask

  task automatic check_dump(input string tag, input logic [7:0] pc);
    logic [31:0] got;
    logic [31:0] exp;
    chk({tag, "_len"}, rx_q.size(), DUMP_BYTES);
    for (int w = 0; w < 65; w++) begin
      if (w == 0) exp = {24'h0, pc};
      else if (w <= 32) exp = regs[w-1];
      else exp = dmem[w-33];
      if (rx_q.size() >= w * 4 + 4) begin
        got = {rx_q[w*4+3], rx_q[w*4+2], rx_q[w*4+1], rx_q[w*4]};
        chk($sformatf("%s_w%0d", tag, w), got, exp);
      end
    end
  endtask

  task automatic rand_state();
    foreach (regs[i]) regs[i] = $urandom;
    foreach (dmem[i]) dmem[i] = $urandom;
    pc_base = 8'($urandom);
  endtask

  int          en0;
  int          c;
  logic [7:0]  b;
  logic [31:0] w;

  initial begin
    rand_state();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_en", en_pipe, 0);
    chk("rst_start", tx_start, 0);
    chk("rst_txd", tx_data, 0);
    chk("rst_dbg", dbg, 1);
    chk("rst_we", im_we, 0);
    chk("rst_ima", im_addr, 0);
    chk("rst_bren", br_en, 0);
    chk("rst_dmen", dm_en, 0);
    chk("rst_bra", br_addr, 0);
    chk("rst_dma", dm_addr, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    ld_q = '{8'h13, 8'h00, 8'h20, 8'h00,
             8'h00, 8'h00, 8'h00, 8'hFC};
    run_load("ld");

    rand_state();
    rx_q.delete();
    en0 = en_total;
    send_byte(8'h53);
    c = 0;
    while (rx_q.size() < 8 && c < 500) begin
      @(negedge clk);
      c++;
    end
    send_byte(8'h53);
    wait_bytes("step", DUMP_BYTES, 5000);
    repeat (30) @(negedge clk);
    chk("step_en", en_total - en0, 1);
    check_dump("step", pc_base + en0[7:0] + 8'd1);

    rand_state();
    rx_q.delete();
    en0 = en_total;
    send_byte(8'h43);
    c = 0;
    while (en_total - en0 < 20 && c < 200) begin
      @(negedge clk);
      c++;
    end
    chk("run_dbg", dbg, 0);
    @(posedge clk);
    #1;
    halt = 1'b1;
    @(negedge clk);
    chk("run_halt_en", en_pipe, 0);
    wait_bytes("run", DUMP_BYTES, 5000);
    chk("run_en", en_total - en0, 20);
    check_dump("run", pc_base + en0[7:0] + 8'd20);

    rand_state();
    rx_q.delete();
    stall = 1'b1;
    ovl_err = 0;
    hold_err = 0;
    en0 = en_total;
    send_byte(8'h53);
    wait_bytes("stall", DUMP_BYTES, DUMP_BYTES * 60);
    chk("stall_en", en_total - en0, 0);
    chk("stall_ovl", ovl_err, 0);
    chk("stall_hold", hold_err, 0);
    check_dump("stall", pc_base + en0[7:0]);
    stall = 1'b0;
    halt = 1'b0;

    ld_q.delete();
    for (int i = 0; i < 256; i++) begin
      do w = $urandom; while (w == HALT);
      for (int k = 0; k < 4; k++) ld_q.push_back(w[k*8 +: 8]);
    end
    for (int k = 0; k < 4; k++) begin
      do b = 8'($urandom);
      while (b == 8'h4C || b == 8'h43 || b == 8'h53);
      ld_q.push_back(b);
    end
    run_load("ovf");

    send_byte(8'h4C);
    send_byte(8'h11);
    send_byte(8'h22);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    ld_q = '{8'h00, 8'h00, 8'h00, 8'hFC};
    run_load("rld");

    halt = 1'b0;
    send_byte(8'h43);
    repeat (5) @(negedge clk);
    chk("rrun_en", en_pipe, 1);
    chk("rrun_dbg", dbg, 0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rrun_rst_en", en_pipe, 0);
    chk("rrun_rst_start", tx_start, 0);
    chk("rrun_rst_dbg", dbg, 1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (5) @(posedge clk);

    $display("%0d/%0d checks passed", n_ok, n_chk);
    $finish;
  end

endmodule
